mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
- Control stage directly upstream of the MemorySystem block: accepts one load/store request at a time via valid/ready handshake.
- Drives MemorySystem's `mem_addr` (address-source select), `mem_data` (write-data select) and `mem_write`.
- Waits out the synchronous block-RAM read latency, captures `read_data` into a response register and holds it until the consumer takes it.
- Keeps wrapping load/store counts for debug.

Parameters:
- READ_LATENCY, 1, clock edges from address sampled by RAM to `read_data` valid; legal 1..4.
- CNT_WIDTH, 16, width of `rd_count` / `wr_count`.

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RST_N  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request
- req_write  input  1  1 = store, 0 = load
- req_addr_sel  input  2  address source select (0=a, 1=b, 2=c, 3=d) forwarded to MemorySystem `mem_addr`
- req_data_sel  input  1  write-data source select forwarded to MemorySystem `mem_data`
- mem_addr  output  2  to MemorySystem address mux select
- mem_data  output  1  to MemorySystem data mux select
- mem_write  output  1  to MemorySystem write enable
- read_data  input  16  from MemorySystem `read_data`
- resp_valid  output  1  load data available
- resp_data  output  16  captured load data
- resp_ready  input  1  consumer accepts response
- busy  output  1  high in any state other than IDLE
- rd_count  output  CNT_WIDTH  completed loads (response handshakes)
- wr_count  output  CNT_WIDTH  issued stores

Behaviour:
- Reset (RST_N low, asynchronous, takes effect immediately with no clock):
  - state = IDLE.
  - `mem_addr`=0, `mem_data`=0, `mem_write`=0.
  - `resp_valid`=0, `resp_data`=0.
  - `rd_count`=0, `wr_count`=0, latency counter=0.
  - `req_ready`=1 and `busy`=0 after reset.
- Reset mid-operation (any state) aborts the access; `mem_write` drops in the same instant; no response is produced.
- All outputs are registered except `req_ready`=(state==IDLE) and `busy`=(state!=IDLE).
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On an edge with `req_valid`=1: register `mem_addr`<=`req_addr_sel`, `mem_data`<=`req_data_sel`, `mem_write`<=`req_write`; go to ISSUE.
  - Requests with `req_valid`=0 are ignored.
- ISSUE (exactly 1 cycle):
  - `mem_addr`/`mem_data` are driven; the RAM samples the address (and data if writing) at the closing edge.
  - Store: `mem_write`=1 for this cycle only; `wr_count` increments at the closing edge; next state IDLE, so `mem_write` is 0 in the next cycle.
  - Load: `mem_write`=0; latency counter loaded with READ_LATENCY-1; go to WAIT.
- WAIT:
  - `mem_addr` is held stable.
  - If counter==0: `resp_data`<=`read_data`, `resp_valid`<=1, go to RESP.
  - Otherwise the counter decrements.
  - Total load latency from the acceptance edge to `resp_valid` high = READ_LATENCY+2 edges (3 for the default).
- RESP:
  - `resp_valid`=1; `resp_data` holds stable regardless of `read_data` changes.
  - On an edge with `resp_ready`=1: `resp_valid`<=0, `rd_count` increments, go to IDLE.
  - Backpressure of any length is legal; no new request is accepted while in RESP.
- `mem_addr` and `mem_data` hold their last values in IDLE; only `mem_write` returns to 0.
- Upstream sources (`addr_*`, `data_*` into MemorySystem) are required to be stable from the acceptance edge through the ISSUE closing edge; this block does not register them.
- Counters wrap modulo 2^CNT_WIDTH (0xFFFF+1 -> 0x0000 for the default).
- Throughput:
  - Back-to-back stores: one per 2 cycles.
  - Loads: one per READ_LATENCY+3 cycles minimum.
- `req_valid` asserted while `req_ready`=0 has no effect; the requester must hold the request until the handshake.

Test Plan:
- Reset: drive RST_N low mid-cycle in ISSUE of a store -> `mem_write` falls immediately; all outputs 0, `req_ready`=1; `wr_count` unchanged at 0.
- Store: request write=1, addr_sel=2, data_sel=1 -> the next cycle shows `mem_addr`=2, `mem_data`=1, `mem_write`=1 for exactly 1 cycle; `wr_count` 0->1; reading that address afterwards returns the written word.
- Load with READ_LATENCY=1: preload mem[0x0010]=0xBEEF, addr source a=0x0010, request write=0, addr_sel=0 -> `resp_valid` rises 3 edges after acceptance with `resp_data`=0xBEEF; `mem_write` never high.
- Backpressure: hold `resp_ready`=0 for 10 cycles while changing RAM output -> `resp_data` stays 0xBEEF, `req_ready`=0, a new `req_valid` is ignored; release -> `rd_count` +1, then IDLE.
- Back-to-back: 4 stores then 4 loads with `req_valid` held high and `resp_ready`=1 -> stores complete on every other edge, each load is 4 cycles; `wr_count`=4, `rd_count`=4.
- Wrap and parameter: preset via 65536 stores (or CNT_WIDTH=4 with 16 stores) -> counter returns to 0; run READ_LATENCY=3 -> load response 5 edges after acceptance.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Sequences one load/store at a time into MemorySystem. A store takes 2 cycles. A load
// raises resp_valid READ_LATENCY+2 edges after acceptance and holds it until resp_ready.
module mem_access_sequencer #(
   parameter int READ_LATENCY = 1,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [1:0]           req_addr_sel,
   input  logic                 req_data_sel,
   output logic [1:0]           mem_addr,
   output logic                 mem_data,
   output logic                 mem_write,
   input  logic [15:0]          read_data,
   output logic                 resp_valid,
   output logic [15:0]          resp_data,
   input  logic                 resp_ready,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] rd_count,
   output logic [CNT_WIDTH-1:0] wr_count
);

   localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] lat_cnt;
   logic       accept, load_lat, capture, resp_done;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      load_lat  = 1'b0;
      capture   = 1'b0;
      resp_done = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            // mem_write still carries the accepted request type here
            if (mem_write) begin
               state_nxt = IDLE;
            end else begin
               load_lat  = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (lat_cnt == 2'd0) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               resp_done = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mem_addr   <= 2'd0;
         mem_data   <= 1'b0;
         mem_write  <= 1'b0;
         resp_valid <= 1'b0;
         resp_data  <= 16'd0;
         rd_count   <= '0;
         wr_count   <= '0;
         lat_cnt    <= 2'd0;
      end else begin
         if (accept) begin
            mem_addr  <= req_addr_sel;
            mem_data  <= req_data_sel;
            mem_write <= req_write;
         end
         if (state == ISSUE) begin
            mem_write <= 1'b0;
            if (mem_write) wr_count <= wr_count + CNT_WIDTH'(1);
         end
         if (load_lat) begin
            lat_cnt <= LAT_INIT;
         end else if (state == WAIT && lat_cnt != 2'd0) begin
            lat_cnt <= lat_cnt - 2'd1;
         end
         if (capture) begin
            resp_data  <= read_data;
            resp_valid <= 1'b1;
         end
         if (resp_done) begin
            resp_valid <= 1'b0;
            rd_count   <= rd_count + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomized bench: a RAM environment model around the sequencer, checked against
// transaction-level expectations (memory image, counters, fixed load latency).
module tb_mem_access_sequencer;

   localparam int RL  = 1;
   localparam int CW  = 4;
   localparam int RL3 = 3;

   logic CLK = 1'b0;
   logic RST_N;
   always #5 CLK = ~CLK;

   logic          req_valid = 1'b0, req_write = 1'b0, req_data_sel = 1'b0, resp_ready = 1'b0;
   logic [1:0]    req_addr_sel = 2'd0;
   logic          req_ready, mem_data, mem_write, resp_valid, busy;
   logic [1:0]    mem_addr;
   logic [15:0]   read_data, resp_data;
   logic [CW-1:0] rd_count, wr_count;

   mem_access_sequencer #(.READ_LATENCY(RL), .CNT_WIDTH(CW)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr_sel(req_addr_sel), .req_data_sel(req_data_sel),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
      .read_data(read_data), .resp_valid(resp_valid), .resp_data(resp_data),
      .resp_ready(resp_ready), .busy(busy), .rd_count(rd_count), .wr_count(wr_count)
   );

   logic          req_valid3 = 1'b0, resp_ready3 = 1'b0;
   logic [1:0]    req_addr_sel3 = 2'd0;
   logic          req_ready3, mem_data3, mem_write3, resp_valid3, busy3;
   logic [1:0]    mem_addr3;
   logic [15:0]   read_data3, resp_data3;
   logic [15:0]   rd_count3, wr_count3;

   mem_access_sequencer #(.READ_LATENCY(RL3)) dut3 (
      .CLK(CLK), .RST_N(RST_N),
      .req_valid(req_valid3), .req_ready(req_ready3), .req_write(1'b0),
      .req_addr_sel(req_addr_sel3), .req_data_sel(1'b0),
      .mem_addr(mem_addr3), .mem_data(mem_data3), .mem_write(mem_write3),
      .read_data(read_data3), .resp_valid(resp_valid3), .resp_data(resp_data3),
      .resp_ready(resp_ready3), .busy(busy3), .rd_count(rd_count3), .wr_count(wr_count3)
   );

   // MemorySystem environment: source muxes plus a synchronous RAM
   logic [15:0] addr_src [4];
   logic [15:0] data_src [2];
   logic [15:0] ram      [256];
   logic [15:0] ref_mem  [256];
   logic [15:0] rd_pipe;
   logic        ovr_en = 1'b0;
   logic [15:0] ovr_val = 16'd0;

   assign read_data = ovr_en ? ovr_val : rd_pipe;

   always @(posedge CLK) begin
      rd_pipe <= ram[addr_src[mem_addr][7:0]];
      if (mem_write) ram[addr_src[mem_addr][7:0]] = data_src[mem_data];
   end

   function automatic logic [15:0] f3(input logic [1:0] a);
      return 16'h5A00 + 16'h0123 * {14'd0, a};
   endfunction

   logic [15:0] p3 [3];
   assign read_data3 = p3[2];
   always @(posedge CLK) begin
      p3[0] <= f3(mem_addr3);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end

   int            n_vec = 0, n_err = 0;
   logic [CW-1:0] exp_wr = '0, exp_rd = '0;
   logic [15:0]   exp_rd3 = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic rand_sources();
      for (int i = 0; i < 4; i++) addr_src[i] = 16'h0010 + 16'($urandom_range(0, 7));
      for (int i = 0; i < 2; i++) data_src[i] = 16'($urandom);
   endtask

   task automatic do_store(input logic [1:0] a, input logic d);
      req_valid = 1'b1; req_write = 1'b1; req_addr_sel = a; req_data_sel = d;
      step();
      chk("st_addr", mem_addr, a);
      chk("st_data", mem_data, d);
      chk("st_we", mem_write, 1);
      chk("st_rdy", req_ready, 0);
      req_valid = 1'b0;
      step();
      ref_mem[addr_src[a][7:0]] = data_src[d];
      exp_wr++;
      chk("st_we_off", mem_write, 0);
      chk("st_wcnt", wr_count, exp_wr);
      chk("st_idle", req_ready, 1);
      chk("st_hold", mem_addr, a);
   endtask

   task automatic do_load(input logic [1:0] a, input int bp);
      int          n;
      logic [15:0] exp;
      req_valid = 1'b1; req_write = 1'b0; req_addr_sel = a; req_data_sel = 1'($urandom);
      step();
      chk("ld_we", mem_write, 0);
      chk("ld_busy", busy, 1);
      req_valid = 1'b0;
      n = 1;
      while (!resp_valid && n < 12) begin
         step();
         n++;
         if (mem_write) chk("ld_we_wait", mem_write, 0);
      end
      chk("ld_lat", n, RL + 2);
      exp = ref_mem[addr_src[a][7:0]];
      chk("ld_dat", resp_data, exp);
      for (int i = 0; i < bp; i++) begin
         ovr_en = 1'b1; ovr_val = 16'($urandom);
         req_valid = 1'b1; req_write = 1'($urandom); req_addr_sel = ~a;
         step();
         chk("bp_dat", resp_data, exp);
         chk("bp_vld", resp_valid, 1);
         chk("bp_rdy", req_ready, 0);
      end
      req_valid = 1'b0; ovr_en = 1'b0; resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      exp_rd++;
      chk("ld_done", resp_valid, 0);
      chk("ld_rcnt", rd_count, exp_rd);
      chk("ld_idle", req_ready, 1);
      chk("ld_hold", mem_addr, a);
   endtask

   task automatic do_load3(input logic [1:0] a);
      int n;
      req_valid3 = 1'b1; req_addr_sel3 = a;
      step();
      req_valid3 = 1'b0;
      n = 1;
      while (!resp_valid3 && n < 12) begin
         step();
         n++;
      end
      chk("ld3_lat", n, RL3 + 2);
      chk("ld3_dat", resp_data3, f3(a));
      resp_ready3 = 1'b1;
      step();
      resp_ready3 = 1'b0;
      exp_rd3++;
      chk("ld3_done", resp_valid3, 0);
      chk("ld3_rcnt", rd_count3, exp_rd3);
   endtask

   initial begin
      logic [1:0] a;
      logic       d;
      for (int i = 0; i < 256; i++) begin
         ram[i] = 16'd0;
         ref_mem[i] = 16'd0;
      end
      ram[16] = 16'hBEEF;
      ref_mem[16] = 16'hBEEF;
      addr_src[0] = 16'h0010; addr_src[1] = 16'h0011;
      addr_src[2] = 16'h0020; addr_src[3] = 16'h0013;
      data_src[0] = 16'($urandom); data_src[1] = 16'($urandom);

      RST_N = 1'b1;
      #1 RST_N = 1'b0;
      #1;
      chk("rst_rdy", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_we", mem_write, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_data", mem_data, 0);
      chk("rst_rv", resp_valid, 0);
      chk("rst_rd", resp_data, 0);
      chk("rst_wcnt", wr_count, 0);
      chk("rst_rcnt", rd_count, 0);
      @(negedge CLK) RST_N = 1'b1;
      step();

      // asynchronous reset while a store sits in ISSUE
      req_valid = 1'b1; req_write = 1'b1; req_addr_sel = 2'd2; req_data_sel = 1'b1;
      step();
      chk("mid_we_pre", mem_write, 1);
      req_valid = 1'b0;
      #2 RST_N = 1'b0;
      #1;
      chk("mid_we", mem_write, 0);
      chk("mid_rdy", req_ready, 1);
      chk("mid_busy", busy, 0);
      chk("mid_addr", mem_addr, 0);
      chk("mid_wcnt", wr_count, 0);
      #1 RST_N = 1'b1;
      step();
      chk("mid_nowrite", ram[8'h20], 0);

      do_store(2'd2, 1'b1);
      do_load(2'd2, 0);
      do_load(2'd0, 10);

      // back-to-back stores then loads with req_valid held high
      rand_sources();
      a = 2'($urandom); d = 1'($urandom);
      req_valid = 1'b1; req_write = 1'b1; req_addr_sel = a; req_data_sel = d;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("b2b_we", mem_write, (k % 2 == 0));
         chk("b2b_srdy", req_ready, (k % 2 == 1));
      end
      ref_mem[addr_src[a][7:0]] = data_src[d];
      exp_wr += 4;
      chk("b2b_wcnt", wr_count, exp_wr);
      req_write = 1'b0; resp_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         step();
         chk("b2b_rv", resp_valid, (k % 4 == 2));
         if (k % 4 == 2) chk("b2b_rd", resp_data, data_src[d]);
         if (k == 14) req_valid = 1'b0;
      end
      resp_ready = 1'b0;
      exp_rd += 4;
      chk("b2b_rcnt", rd_count, exp_rd);

      for (int t = 0; t < 24; t++) begin
         rand_sources();
         if ($urandom_range(0, 1) == 1) do_store(2'($urandom), 1'($urandom));
         else                           do_load(2'($urandom), int'($urandom_range(0, 4)));
      end

      // counter wrap at 2^CW
      for (int t = 0; t < 20 && exp_wr != '1; t++) do_store(2'($urandom), 1'($urandom));
      do_store(2'($urandom), 1'($urandom));
      chk("wrap_w", wr_count, 0);
      for (int t = 0; t < 20 && exp_rd != '1; t++) do_load(2'($urandom), 0);
      do_load(2'($urandom), 0);
      chk("wrap_r", rd_count, 0);

      for (int t = 0; t < 3; t++) do_load3(2'($urandom));
      chk("d3_wcnt", wr_count3, 0);
      chk("d3_we", mem_write3, 0);
      chk("d3_rdy", req_ready3, 1);
      chk("d3_busy", busy3, 0);
      chk("d3_data", mem_data3, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
